// File: rtl/hypot_iter.sv
// hypot_iter: iterative integer sqrt(a*a + b*b) with optional rounding, valid/ready handshakes.
module hypot_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             round_en_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   root_o,
  output logic             exact_o
);
  localparam int SUM_W  = 2 * WIDTH + 1;
  localparam int ROOT_W = WIDTH + 1;
  localparam int CNT_W  = $clog2(ROOT_W);
  typedef enum logic [1:0] {IDLE, SQUARE, ROOT, DONE} state_t;
  state_t              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic                rnd_q, rnd_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [ROOT_W+1:0]   rem_q, rem_d, rem_nx;
  logic [ROOT_W-1:0]   q_q, q_d, q_nx;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ROOT_W-1:0]   root_q, root_d;
  logic                exact_q, exact_d;
  logic [2*ROOT_W-1:0] pad;
  logic [ROOT_W+3:0]   rem_sh, trial;
  logic                ge;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rnd_q   <= 1'b0;
      sum_q   <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      root_q  <= '0;
      exact_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rnd_q   <= rnd_d;
      sum_q   <= sum_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      root_q  <= root_d;
      exact_q <= exact_d;
    end
  end
  // one restoring-root step: bring down the next bit pair of the sum, MSB pair first
  always_comb begin
    pad    = {1'b0, sum_q};
    rem_sh = {rem_q, pad[{cnt_q, 1'b0} +: 2]};
    trial  = {2'b00, q_q, 2'b01};
    ge     = rem_sh >= trial;
    rem_nx = (ROOT_W+2)'(ge ? rem_sh - trial : rem_sh);
    q_nx   = {q_q[ROOT_W-2:0], ge};
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    rnd_d   = rnd_q;
    sum_d   = sum_q;
    rem_d   = rem_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    root_d  = root_q;
    exact_d = exact_q;
    case (state_q)
      IDLE: if (in_valid_i) begin
        a_d     = a_i;
        b_d     = b_i;
        rnd_d   = round_en_i;
        state_d = SQUARE;
      end
      SQUARE: begin
        sum_d   = SUM_W'(a_q) * SUM_W'(a_q) + SUM_W'(b_q) * SUM_W'(b_q);
        rem_d   = '0;
        q_d     = '0;
        cnt_d   = CNT_W'(ROOT_W - 1);
        state_d = ROOT;
      end
      ROOT: begin
        rem_d = rem_nx;
        q_d   = q_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          // rem > q is the same test as N > q*q + q, i.e. the fraction exceeds one half
          root_d  = q_nx + ROOT_W'(rnd_q && (rem_nx > {2'b00, q_nx}));
          exact_d = rem_nx == '0;
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready_i ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  assign in_ready_o  = state_q == IDLE;
  assign out_valid_o = state_q == DONE;
  assign root_o      = root_q;
  assign exact_o     = exact_q;
endmodule

// File: tb/tb_hypot_iter.sv
// tb_hypot_iter: drives WIDTH=4/8/12 instances and checks results against an arithmetic sqrt model.
module tb_hypot_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [11:0] a_s = '0, b_s = '0;
  logic        rnd = 1'b0, ordy = 1'b0;
  logic [2:0]  iv = '0;
  wire  [2:0]  ir, ov, ex;
  wire  [4:0]  r4;
  wire  [8:0]  r8;
  wire  [12:0] r12;
  int n_tests = 0, n_fail = 0;
  hypot_iter #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .in_valid_i(iv[0]), .in_ready_o(ir[0]),
    .a_i(a_s[3:0]), .b_i(b_s[3:0]), .round_en_i(rnd), .out_valid_o(ov[0]), .out_ready_i(ordy),
    .root_o(r4), .exact_o(ex[0]));
  hypot_iter #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .in_valid_i(iv[1]), .in_ready_o(ir[1]),
    .a_i(a_s[7:0]), .b_i(b_s[7:0]), .round_en_i(rnd), .out_valid_o(ov[1]), .out_ready_i(ordy),
    .root_o(r8), .exact_o(ex[1]));
  hypot_iter #(.WIDTH(12)) u12 (.clk(clk), .rst(rst), .in_valid_i(iv[2]), .in_ready_o(ir[2]),
    .a_i(a_s), .b_i(b_s), .round_en_i(rnd), .out_valid_o(ov[2]), .out_ready_i(ordy),
    .root_o(r12), .exact_o(ex[2]));
  // nearest integer to the real square root; ties cannot occur for integer N
  function automatic void ref_hyp(input longint a, input longint b, input bit r,
                                  output longint root, output bit exact);
    longint n, s;
    n = a * a + b * b;
    s = longint'($rtoi($sqrt(real'(n))));
    while (s * s > n) s--;
    while ((s + 1) * (s + 1) <= n) s++;
    exact = (s * s == n);
    root  = (r && (n - s * s > (s + 1) * (s + 1) - n)) ? s + 1 : s;
  endfunction
  task automatic xact(input int sel, input logic [11:0] a, input logic [11:0] b, input bit r,
                      output logic [12:0] root, output bit exact, output int lat);
    @(posedge clk); #1;
    a_s = a; b_s = b; rnd = r; iv = '0; iv[sel] = 1'b1;
    @(posedge clk); #1;
    iv = '0; lat = 0;
    while (!ov[sel] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    root  = sel == 0 ? 13'(r4) : sel == 1 ? 13'(r8) : r12;
    exact = ex[sel];
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
  endtask
  task automatic test_reset();
    #2;
    n_tests++;
    if (ir !== 3'b111 || ov !== 3'b000 || ex !== 3'b000 || r4 !== '0 || r8 !== '0 || r12 !== '0) begin
      n_fail++;
      $display("FAIL reset: in_ready=%b out_valid=%b exact=%b roots=%0d/%0d/%0d, want 111 000 000 0/0/0",
               ir, ov, ex, r4, r8, r12);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask
  task automatic test_vectors();
    int va[10] = '{3, 6, 5, 2, 2, 1, 255, 255, 0, 0};
    int vb[10] = '{4, 8, 12, 3, 3, 1, 255, 255, 0, 200};
    bit vr[10] = '{0, 0, 0, 0, 1, 1, 0, 1, 0, 0};
    int er[10] = '{5, 10, 13, 3, 4, 1, 360, 361, 0, 200};
    bit ee[10] = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1};
    logic [12:0] root;
    bit exact;
    int lat;
    for (int i = 0; i < 10; i++) begin
      xact(1, 12'(va[i]), 12'(vb[i]), vr[i], root, exact, lat);
      n_tests++;
      if (root !== 13'(er[i]) || exact !== ee[i] || lat != 10) begin
        n_fail++;
        $display("FAIL vec8(%0d,%0d,r=%0d): root=%0d exact=%0d lat=%0d, want %0d %0d 10",
                 va[i], vb[i], vr[i], root, exact, lat, er[i], ee[i]);
      end
    end
  endtask
  task automatic test_handshake();
    int lat = 0;
    @(posedge clk); #1;
    a_s = 3; b_s = 4; rnd = 0; iv[1] = 1'b1;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    while (!ov[1] && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int i = 0; i < 6; i++) begin
      n_tests++;
      if (ov[1] !== 1'b1 || r8 !== 9'd5 || ex[1] !== 1'b1 || ir[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d]: out_valid=%b root=%0d exact=%b in_ready=%b, want 1 5 1 0",
                 i, ov[1], r8, ex[1], ir[1]);
      end
      if (i == 2) begin a_s = 5; b_s = 12; iv[1] = 1'b1; end
      else iv[1] = 1'b0;
      if (i < 5) begin @(posedge clk); #1; end
    end
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    for (int i = 0; i < 13; i++) begin
      n_tests++;
      if (ir[1] !== 1'b1 || ov[1] !== 1'b0) begin
        n_fail++;
        $display("FAIL release[%0d]: in_ready=%b out_valid=%b, want 1 0", i, ir[1], ov[1]);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset_midop();
    logic [12:0] root;
    bit exact;
    int lat;
    @(posedge clk); #1;
    a_s = 5; b_s = 12; rnd = 0; iv[1] = 1'b1;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (ov[1] !== 1'b0 || ir[1] !== 1'b1 || r8 !== '0) begin
      n_fail++;
      $display("FAIL midop_reset: out_valid=%b in_ready=%b root=%0d, want 0 1 0", ov[1], ir[1], r8);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    xact(1, 12'd3, 12'd4, 1'b0, root, exact, lat);
    n_tests++;
    if (root !== 13'd5 || exact !== 1'b1 || lat != 10) begin
      n_fail++;
      $display("FAIL after_reset(3,4): root=%0d exact=%0d lat=%0d, want 5 1 10", root, exact, lat);
    end
  endtask
  task automatic test_width4();
    logic [12:0] root;
    bit exact;
    int lat;
    for (int r = 0; r < 2; r++) begin
      xact(0, 12'd15, 12'd15, r[0], root, exact, lat);
      n_tests++;
      if (root !== 13'd21 || exact !== 1'b0 || lat != 6) begin
        n_fail++;
        $display("FAIL w4(15,15,r=%0d): root=%0d exact=%0d lat=%0d, want 21 0 6", r, root, exact, lat);
      end
    end
  endtask
  task automatic test_random(input int sel, input int w, input int pairs);
    logic [12:0] root;
    bit exact, ee;
    int lat;
    longint er;
    logic [11:0] a, b;
    for (int i = 0; i < pairs; i++) begin
      a = 12'($urandom_range((1 << w) - 1));
      b = 12'($urandom_range((1 << w) - 1));
      if (i == 0) begin a = 12'((1 << w) - 1); b = a; end
      if (i == 1) begin a = 0; b = 12'((1 << w) - 1); end
      for (int r = 0; r < 2; r++) begin
        ref_hyp(longint'(a), longint'(b), r[0], er, ee);
        xact(sel, a, b, r[0], root, exact, lat);
        n_tests++;
        if (root !== 13'(er) || exact !== ee || lat != w + 2) begin
          n_fail++;
          $display("FAIL rand_w%0d(%0d,%0d,r=%0d): root=%0d exact=%0d lat=%0d, want %0d %0d %0d",
                   w, a, b, r, root, exact, lat, er, ee, w + 2);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_vectors();
    test_handshake();
    test_reset_midop();
    test_width4();
    test_random(1, 8, 100);
    test_random(2, 12, 1000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hypot_iter.md
Name: hypot_iter

Overview:
- Iterative integer hypotenuse unit: accepts operands a and b and returns sqrt(a*a + b*b), either truncated or rounded, plus an exactness flag.
- Parametrised sequential successor to the combinational hypotenuse add-on.
- Uses one multiply stage, then a digit-by-digit restoring square root producing one result bit per cycle.
- Valid/ready handshakes on input and output, so it can sit between the pin-level wrapper and downstream logic.

Parameters:
- WIDTH, 8, operand width in bits (>= 2).
- SUM_W, 2*WIDTH+1, derived; width of a*a + b*b.
- ROOT_W, WIDTH+1, derived; result width and number of root iterations.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  unit can accept operands
- a  input  WIDTH  operand a, unsigned
- b  input  WIDTH  operand b, unsigned
- round_en  input  1  1 = round to nearest, 0 = floor; sampled with operands
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- root  output  ROOT_W  result
- exact  output  1  a*a + b*b is a perfect square

Behaviour:
- Reset values (asynchronous assert, synchronous deassert by user): state=IDLE, in_ready=1, out_valid=0, root=0, exact=0; all internal registers 0.
- Reset asserted in any state aborts the operation. No result is emitted for the aborted operands.

FSM:
- IDLE: in_ready=1. On in_valid at an edge, capture a, b, round_en and go to SQUARE.
- SQUARE: in_ready=0. Register sum = a*a + b*b, zero-extended to SUM_W. Clear remainder and partial root. Load the iteration counter with ROOT_W-1. Go to ROOT.
- ROOT: in_ready=0. Restoring square root, one bit per cycle, MSB pair first.
  - Each cycle: rem' = (rem<<2) | next two sum bits (sum padded to 2*ROOT_W bits); trial = (q<<2)|1.
  - If rem' >= trial: rem = rem' - trial and q = (q<<1)|1. Otherwise rem = rem' and q = q<<1.
  - After ROOT_W iterations go to DONE.
  - On the transition into DONE:
    - root = q + (round_en && rem > q ? 1 : 0).
    - exact = (rem == 0).
- DONE: out_valid=1; root and exact stay stable. When out_ready=1 at an edge, go to IDLE and set out_valid=0.
- in_ready rises on the cycle after the output handshake; there is no same-cycle reissue.

Timing:
- Latency: with acceptance at edge E0, out_valid rises after edge E0+ROOT_W+1 (10 cycles for WIDTH=8).
- Maximum throughput: one result per ROOT_W+3 cycles.
- Backpressure: out_valid is held indefinitely while out_ready=0. in_valid is ignored outside IDLE.
- out_ready is ignored while out_valid=0.

Arithmetic:
- All unsigned.
- rem is ROOT_W+2 bits and q is ROOT_W bits; neither overflows.
- Rounding rule: N > q*q + q is equivalent to rem > q.
- Rounded root never exceeds ROOT_W bits; worst case for WIDTH=8 is 361.
- exact refers to the floor remainder, independent of round_en.

Boundaries:
- a=b=0 gives root=0, exact=1.
- A single nonzero operand gives root equal to that operand, exact=1.

Test Plan:
- WIDTH=8, round_en=0:
  - (3,4) -> root=5, exact=1, out_valid exactly 10 cycles after the accept edge.
  - (6,8) -> 10, exact=1.
  - (5,12) -> 13, exact=1.
- Rounding, WIDTH=8:
  - (2,3): round_en=0 -> 3, exact=0; round_en=1 -> 4.
  - (1,1): round_en=1 -> 1, exact=0.
- Extremes, WIDTH=8:
  - (255,255): round_en=0 -> 360; round_en=1 -> 361; exact=0.
  - (0,0) -> 0, exact=1.
  - (0,200) -> 200, exact=1.
- Handshake: hold out_ready=0 for 5 cycles after out_valid rises -> root/exact/out_valid stable, in_ready=0 throughout. A new in_valid pulse in that window is ignored. After out_ready=1, in_ready=1 the next cycle.
- Reset mid-op: assert rst during ROOT iteration 4 of (5,12) -> immediately out_valid=0, in_ready=1, root=0. A subsequent (3,4) -> 5 with normal latency.
- Parametrisation: WIDTH=4, operands (15,15) -> 21 floor, 21 rounded, exact=0; latency 6 cycles. WIDTH=12 random sweep of 1000 pairs checked against a reference model for both round_en values.
